// File: rtl/uart_tx.sv
// UART transmitter with one-word holding buffer and 16x tick-driven framing.
// Optional even parity bit when UART_TX_PARITY_EN is defined.
module uart_tx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            wr_en,
  input  logic [DBIT-1:0] din,
  output logic            tx_full,
  output logic            tx_busy,
  output logic            tx_done_tick,
  output logic            tx
);

  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam logic [SW-1:0] S_BIT_END  = SW'(15);
  localparam logic [SW-1:0] S_STOP_END = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST     = NW'(DBIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_e;

  state_e          state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic [DBIT-1:0] hold_q, hold_d;
  logic            full_q, full_d;
  logic            tx_q, tx_d;
  logic            busy_q;
  logic            done_q, done_d;
`ifdef UART_TX_PARITY_EN
  logic            par_q, par_d;
`endif

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    hold_d  = hold_q;
    full_d  = full_q;
    done_d  = 1'b0;
    tx_d    = 1'b1;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (full_q) begin
          b_d     = hold_q;
          full_d  = 1'b0;
          s_d     = '0;
          state_d = START;
`ifdef UART_TX_PARITY_EN
          par_d   = ^hold_q;
`endif
        end
      end
      START: begin
        if (s_tick) begin
          if (s_q == S_BIT_END) begin
            s_d     = '0;
            n_d     = '0;
            state_d = DATA;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_q == S_BIT_END) begin
            s_d = '0;
            b_d = b_q >> 1;
            if (n_q == N_LAST) begin
`ifdef UART_TX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              n_d = n_q + NW'(1);
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (s_tick) begin
          if (s_q == S_BIT_END) begin
            s_d     = '0;
            state_d = STOP;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
`endif
      STOP: begin
        if (s_tick) begin
          if (s_q == S_STOP_END) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A drain needs full_q=1, so it can never collide with an accepted write
    if (wr_en && !full_q) begin
      hold_d = din;
      full_d = 1'b1;
    end

    // Line value follows the next state so tx switches with the transition
    unique case (1'b1)
      (state_d == START): tx_d = 1'b0;
      (state_d == DATA):  tx_d = b_d[0];
`ifdef UART_TX_PARITY_EN
      (state_d == PARITY): tx_d = par_d;
`endif
      default:            tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      hold_q  <= '0;
      full_q  <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      hold_q  <= hold_d;
      full_q  <= full_d;
      tx_q    <= tx_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign tx           = tx_q;
  assign tx_full      = full_q;
  assign tx_busy      = busy_q;
  assign tx_done_tick = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: tick-count frame model, line monitor and directed cases.
// Parity cases are included when UART_TX_PARITY_EN is defined.
module tb_uart_tx;

  localparam int DBIT = 8;
  localparam int SB   = 16;
`ifdef UART_TX_PARITY_EN
  localparam int P        = 1;
  localparam int FLEN_LIT = 176;
`else
  localparam int P        = 0;
  localparam int FLEN_LIT = 160;
`endif
  localparam int FLEN = (1 + DBIT + P) * 16 + SB;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       s_tick = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] din = 8'h00;
  logic       tx_full, tx_busy, tx_done_tick, tx;

  uart_tx #(.DBIT(DBIT), .SB_TICK(SB)) dut (
    .clk         (clk),
    .reset       (reset),
    .s_tick      (s_tick),
    .wr_en       (wr_en),
    .din         (din),
    .tx_full     (tx_full),
    .tx_busy     (tx_busy),
    .tx_done_tick(tx_done_tick),
    .tx          (tx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit armed = 1'b0;
  int tick_div = 3;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  initial begin
    int c = 0;
    forever begin
      @(negedge clk);
      #1;
      if (tick_div <= 1) s_tick = 1'b1;
      else begin
        s_tick = ((c % tick_div) == 0);
        c++;
      end
    end
  end

  // Frame model: a frame is just a tick count since START entry
  logic       m_active, m_full, m_done;
  logic [7:0] m_hold, m_word;
  int         m_ticks;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_active <= 1'b0;
      m_full   <= 1'b0;
      m_done   <= 1'b0;
      m_hold   <= 8'h00;
      m_word   <= 8'h00;
      m_ticks  <= 0;
    end else begin
      m_done <= m_active && s_tick && (m_ticks + 1 == FLEN);
      if (!m_active && m_full) begin
        m_active <= 1'b1;
        m_ticks  <= 0;
        m_word   <= m_hold;
        m_full   <= 1'b0;
      end else begin
        if (m_active && s_tick) begin
          if (m_ticks + 1 == FLEN) m_active <= 1'b0;
          m_ticks <= m_ticks + 1;
        end
        if (wr_en && !m_full) begin
          m_full <= 1'b1;
          m_hold <= din;
        end
      end
    end
  end

  function automatic logic exp_tx();
    int idx;
    if (!m_active) return 1'b1;
    idx = m_ticks / 16;
    if (idx == 0) return 1'b0;
    if (idx <= DBIT) return m_word[idx-1];
    if (P == 1 && idx == DBIT + 1) return ^m_word;
    return 1'b1;
  endfunction

  // Line monitor, independent of the model
  bit         mon_active = 1'b0;
  int         mon_ticks = 0;
  logic       bits [0:15];
  int         frame_ticks = 0;
  int         done_cnt = 0;
  int         done_cyc = -100;
  int         gap = -1;
  int         start_cyc = 0;
  int         wr_cyc = 0;
  logic [7:0] rxq [$];

  initial begin
    logic [7:0] w;
    forever begin
      @(negedge clk);
      cyc++;
      if (armed && !reset) begin
        check("tx", tx, exp_tx());
        check("tx_full", tx_full, m_full);
        check("tx_busy", tx_busy, m_active);
        check("tx_done_tick", tx_done_tick, m_done);
        if (!mon_active && tx == 1'b0) begin
          mon_active = 1'b1;
          mon_ticks  = 0;
          start_cyc  = cyc;
          gap        = cyc - done_cyc;
        end else if (mon_active && s_tick) begin
          mon_ticks++;
          if (mon_ticks % 16 == 8) bits[mon_ticks/16] = tx;
        end
        if (tx_done_tick) begin
          check("busy_at_done", tx_busy, 0);
          frame_ticks = mon_ticks;
          mon_active  = 1'b0;
          done_cnt++;
          done_cyc = cyc;
          for (int i = 0; i < 8; i++) w[i] = bits[i+1];
          rxq.push_back(w);
        end
      end else begin
        mon_active = 1'b0;
      end
    end
  end

  task automatic write(input logic [7:0] b);
    @(negedge clk);
    #1;
    wr_en  = 1'b1;
    din    = b;
    wr_cyc = cyc;
    @(negedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic wait_done(input int prev);
    int k = 0;
    while (done_cnt == prev && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check("done_timeout", (done_cnt != prev), 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_ticks(input int t);
    int k = 0;
    while (!(mon_active && mon_ticks >= t) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check("tick_wait_timeout", (k < 3000), 1);
  endtask

  int lit_a5 [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
  logic [7:0] got;

  initial begin
    // Asynchronous reset between clock edges
    #12;
    reset = 1'b1;
    #1;
    check("rst_tx", tx, 1);
    check("rst_full", tx_full, 0);
    check("rst_busy", tx_busy, 0);
    check("rst_done", tx_done_tick, 0);
    repeat (3) @(negedge clk);
    #1;
    reset = 1'b0;
    armed = 1'b1;
    repeat (4) @(negedge clk);

    // Single frame 0xA5
    write(8'hA5);
    wait_done(0);
    check("a5_latency", start_cyc - wr_cyc, 2);
`ifdef UART_TX_PARITY_EN
    lit_a5[9] = 0;
`endif
    for (int i = 0; i < 10; i++)
      check($sformatf("a5_bit%0d", i), bits[i], lit_a5[i]);
    check("a5_ticks", frame_ticks, FLEN_LIT);
    check("a5_done_cnt", done_cnt, 1);
    got = rxq.pop_front();
    check("a5_word", got, 8'hA5);

    // Back-to-back with an overflow write
    write(8'h3C);
    wait_ticks(40);
    write(8'hC3);
    check("b2b_full", tx_full, 1);
    write(8'hFF);
    check("ovf_full", tx_full, 1);
    wait_done(1);
    wait_done(2);
    check("b2b_gap", gap, 1);
    check("b2b_done_cnt", done_cnt, 3);
    check("b2b_q", rxq.size(), 2);
    got = rxq.pop_front();
    check("b2b_word0", got, 8'h3C);
    got = rxq.pop_front();
    check("b2b_word1", got, 8'hC3);

    // Reset during data bit 3 of 0x55
    write(8'h55);
    wait_ticks(16 * 4 + 4);
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("mid_rst_tx", tx, 1);
    check("mid_rst_busy", tx_busy, 0);
    check("mid_rst_full", tx_full, 0);
    repeat (2) @(negedge clk);
    #1;
    reset = 1'b0;
    write(8'h0F);
    wait_done(3);
    check("mid_rst_done_cnt", done_cnt, 4);
    check("mid_rst_q", rxq.size(), 1);
    got = rxq.pop_front();
    check("mid_rst_word", got, 8'h0F);

    // s_tick held high
    tick_div = 1;
    write(8'h81);
    wait_done(4);
    check("cont_ticks", frame_ticks, FLEN_LIT);
    got = rxq.pop_front();
    check("cont_word", got, 8'h81);
    tick_div = 3;

`ifdef UART_TX_PARITY_EN
    write(8'h07);
    wait_done(5);
    check("par07_bit", bits[9], 1);
    check("par07_ticks", frame_ticks, 176);
    write(8'h03);
    wait_done(6);
    check("par03_bit", bits[9], 0);
    got = rxq.pop_front();
    check("par07_word", got, 8'h07);
    got = rxq.pop_front();
    check("par03_word", got, 8'h03);
`endif

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
